// File: rtl/cpu_id_ex_pipe_reg.sv
// Elastic decode->execute pipeline register with flush, bubble sanitising and writeback refresh.
// Optional CPU_EXEC_SKID_EN adds a skid entry so in_ready is registered.
module cpu_id_ex_pipe_reg #(
  parameter int VADDR_W     = 32,
  parameter int REG_W       = 32,
  parameter int NUM_REGS    = 32,
  parameter int NUM_ALU_OPS = 16,
  localparam int REG_ID_W   = $clog2(NUM_REGS),
  localparam int ALU_OP_W   = $clog2(NUM_ALU_OPS),
  localparam int CTRL_W     = ALU_OP_W + 6,
  localparam int IDS_W      = 3 * REG_ID_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [VADDR_W-1:0] in_pc,
  input  logic [REG_W-1:0]   in_ra,
  input  logic [REG_W-1:0]   in_rb,
  input  logic [REG_W-1:0]   in_off,
  input  logic [IDS_W-1:0]   in_ids,
  input  logic               wb_en,
  input  logic [REG_ID_W-1:0] wb_id,
  input  logic [REG_W-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [VADDR_W-1:0] out_pc,
  output logic [REG_W-1:0]   out_ra,
  output logic [REG_W-1:0]   out_rb,
  output logic [REG_W-1:0]   out_off,
  output logic [IDS_W-1:0]   out_ids
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [VADDR_W-1:0] pc;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [REG_W-1:0]   off;
    logic [IDS_W-1:0]   ids;
  } entry_t;

  // branch, mem_write, mem_read and reg_write: side-effecting bits cleared on a bubble
  localparam logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(6'b01_1101);

  // Operand bypass from writeback; register 0 is not special.
  function automatic entry_t refresh(input entry_t e, input logic en,
                                     input logic [REG_ID_W-1:0] id,
                                     input logic [REG_W-1:0] data);
    entry_t r;
    r = e;
    if (en && (id == e.ids[3*REG_ID_W-1 -: REG_ID_W])) r.ra = data;
    if (en && (id == e.ids[2*REG_ID_W-1 -: REG_ID_W])) r.rb = data;
    return r;
  endfunction

  entry_t in_ent;
  entry_t in_fix;
  entry_t out_q;
  entry_t out_fix;
  logic   out_valid_q;
  logic   accept;

  assign in_ent  = {in_ctrl, in_pc, in_ra, in_rb, in_off, in_ids};
  assign in_fix  = refresh(in_ent, wb_en, wb_id, wb_data);
  assign out_fix = refresh(out_q, wb_en, wb_id, wb_data);
  assign accept  = in_valid && in_ready && !flush;

`ifdef CPU_EXEC_SKID_EN
  entry_t skid_q;
  entry_t skid_fix;
  logic   skid_valid_q;

  assign skid_fix = refresh(skid_q, wb_en, wb_id, wb_data);
  // Registered: depends only on skid occupancy, never on out_ready.
  assign in_ready = !skid_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q) begin
      // skid is always empty while the output slot is empty
      if (accept) begin
        out_q       <= in_fix;
        out_valid_q <= 1'b1;
      end
    end else if (out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_fix;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q <= in_fix;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else begin
      out_q <= out_fix;
      if (accept) begin
        skid_q       <= in_fix;
        skid_valid_q <= 1'b1;
      end else if (skid_valid_q) begin
        skid_q <= skid_fix;
      end
    end
  end
`else
  assign in_ready = out_ready || !out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= in_fix;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      out_q <= out_fix;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_valid_q ? out_q.ctrl : (out_q.ctrl & ~KILL_MASK);
  assign out_pc    = out_q.pc;
  assign out_ra    = out_q.ra;
  assign out_rb    = out_q.rb;
  assign out_off   = out_q.off;
  assign out_ids   = out_q.ids;

endmodule

// File: tb/tb_cpu_id_ex_pipe_reg.sv
// Directed bench for cpu_id_ex_pipe_reg: scoreboard queue of expected entries plus inline checks.
// Honours CPU_EXEC_SKID_EN when the design is built with it.
module tb_cpu_id_ex_pipe_reg;
  localparam int VADDR_W  = 32;
  localparam int REG_W    = 32;
  localparam int REG_ID_W = 5;
  localparam int CTRL_W   = 10;
  localparam int IDS_W    = 15;
  localparam int EW       = CTRL_W + VADDR_W + 3*REG_W + IDS_W;

  localparam logic [CTRL_W-1:0] C_RW  = 10'h001;
  localparam logic [CTRL_W-1:0] C_MTR = 10'h002;
  localparam logic [CTRL_W-1:0] C_MR  = 10'h004;
  localparam logic [CTRL_W-1:0] C_MW  = 10'h008;
  localparam logic [CTRL_W-1:0] C_BR  = 10'h010;
  localparam logic [CTRL_W-1:0] C_URB = 10'h020;

`ifdef CPU_EXEC_SKID_EN
  localparam logic HELD_READY = 1'b1;
`else
  localparam logic HELD_READY = 1'b0;
`endif

  logic clk, reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [CTRL_W-1:0]   in_ctrl, out_ctrl;
  logic [VADDR_W-1:0]  in_pc, out_pc;
  logic [REG_W-1:0]    in_ra, in_rb, in_off, out_ra, out_rb, out_off, wb_data;
  logic [IDS_W-1:0]    in_ids, out_ids;
  logic [REG_ID_W-1:0] wb_id;

  cpu_id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_ra(in_ra), .in_rb(in_rb),
    .in_off(in_off), .in_ids(in_ids),
    .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .out_ra(out_ra), .out_rb(out_rb),
    .out_off(out_off), .out_ids(out_ids)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [CTRL_W-1:0] c, input logic [31:0] pc,
                                       input logic [31:0] ra, input logic [31:0] rb,
                                       input logic [31:0] off, input logic [4:0] ra_id,
                                       input logic [4:0] rb_id, input logic [4:0] dst);
    return {c, pc, ra, rb, off, ra_id, rb_id, dst};
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [EW-1:0] e);
    in_valid = 1'b1;
    {in_ctrl, in_pc, in_ra, in_rb, in_off, in_ids} = e;
  endtask

  // scoreboard monitor: pops on every output handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got pc %0h, expected no entry", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_entry", {out_ctrl, out_pc, out_ra, out_rb, out_off, out_ids}, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] e;
    logic [CTRL_W-1:0] c;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_pc = '0; in_ra = '0; in_rb = '0; in_off = '0; in_ids = '0;
    wb_en = 1'b0; wb_id = '0; wb_data = '0;
    cycle(); cycle();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_ra", out_ra, 0);
    check("rst_in_ready", in_ready, 1);

    // reset mid-stream with entries pending
    for (int i = 0; i < 3; i++) begin
      drive(mk(C_RW | C_MW, 32'h300 + 32'(4*i), 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3));
      cycle();
    end
    check("mid_pending_valid", out_valid, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_ctrl", out_ctrl, 0);
    check("mid_rst_in_ready", in_ready, 1);

    // back-to-back stream, including same-cycle accept refresh and r0 refresh
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_en = 1'b0; wb_id = '0; wb_data = '0;
      if (i < 8) begin
        c = (CTRL_W'(i) << 6) | C_RW | ((i % 2 == 1) ? C_MR : C_BR);
        e = mk(c, 32'h100 + 32'(4*i), 32'(i), 32'h50 + 32'(i), 32'h70 + 32'(i),
               5'(i + 10), 5'(i + 20), 5'(i));
        drive(e);
        exp_q.push_back(e);
      end else if (i == 8) begin
        c = (CTRL_W'(8) << 6) | 10'h03F;
        drive(mk(c, 32'h120, 32'h33, 32'h34, 32'h35, 5'd3, 5'd6, 5'd7));
        wb_en = 1'b1; wb_id = 5'd3; wb_data = 32'h99;
        exp_q.push_back(mk(c, 32'h120, 32'h99, 32'h34, 32'h35, 5'd3, 5'd6, 5'd7));
      end else begin
        c = (CTRL_W'(9) << 6) | 10'h03F;
        drive(mk(c, 32'h124, 32'h43, 32'h44, 32'h45, 5'd4, 5'd0, 5'd8));
        wb_en = 1'b1; wb_id = 5'd0; wb_data = 32'h77;
        exp_q.push_back(mk(c, 32'h124, 32'h43, 32'h77, 32'h45, 5'd4, 5'd0, 5'd8));
      end
      cycle();
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, 32'h100 + 32'(4*i));
    end
    in_valid = 1'b0; wb_en = 1'b0;
    cycle();
    check("bubble_valid", out_valid, 0);
    check("bubble_ctrl", out_ctrl, 10'h262);
    check("bubble_pc_hold", out_pc, 32'h124);

    // stall + refresh of the held entry, and in_ready under backpressure
    out_ready = 1'b0;
    e = mk(10'h0E1, 32'h200, 32'h11, 32'h22, 32'h33, 5'd5, 5'd6, 5'd7);
    drive(e);
    exp_q.push_back(mk(10'h0E1, 32'h200, 32'hAB, 32'h22, 32'h33, 5'd5, 5'd6, 5'd7));
    cycle();
    in_valid = 1'b0;
    check("hold_ra_before", out_ra, 32'h11);
    check("held_in_ready", in_ready, HELD_READY);
    wb_en = 1'b1; wb_id = 5'd5; wb_data = 32'hAB;
    cycle();
    wb_en = 1'b0;
    check("refresh_ra", out_ra, 32'hAB);
    check("refresh_rb", out_rb, 32'h22);
    check("refresh_pc", out_pc, 32'h200);
    check("refresh_ctrl", out_ctrl, 10'h0E1);
    check("refresh_ids", out_ids, {5'd5, 5'd6, 5'd7});
    check("refresh_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    cycle();
    check("after_consume_valid", out_valid, 0);

    // flush kills the held entry and the incoming one
    out_ready = 1'b0;
    drive(mk(C_RW | C_MW | (CTRL_W'(5) << 6), 32'h400, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3));
    cycle();
    check("flush_pre_valid", out_valid, 1);
    drive(mk(C_RW, 32'h500, 32'h9, 32'h9, 32'h9, 5'd1, 5'd2, 5'd3));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 10'h140);
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("flush_stays_empty", out_valid, 0);

`ifdef CPU_EXEC_SKID_EN
    // skid: two entries under backpressure, released in order
    out_ready = 1'b0;
    e = mk(C_RW | C_MTR, 32'h600, 32'h61, 32'h62, 32'h63, 5'd8, 5'd9, 5'd10);
    drive(e);
    exp_q.push_back(e);
    cycle();
    check("skid_ready_a", in_ready, 1);
    drive(mk(C_MR | C_URB, 32'h604, 32'h71, 32'h72, 32'h73, 5'd12, 5'd13, 5'd14));
    exp_q.push_back(mk(C_MR | C_URB, 32'h604, 32'h5A, 32'h72, 32'h73, 5'd12, 5'd13, 5'd14));
    cycle();
    in_valid = 1'b0;
    check("skid_ready_full", in_ready, 0);
    check("skid_out_a", out_pc, 32'h600);
    wb_en = 1'b1; wb_id = 5'd12; wb_data = 32'h5A;
    cycle();
    wb_en = 1'b0;
    check("skid_a_still", out_pc, 32'h600);
    out_ready = 1'b1;
    cycle();
    check("skid_out_b", out_pc, 32'h604);
    check("skid_ready_back", in_ready, 1);
    cycle();
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
